uart_tx: RTL
============

# uart_tx

Serial UART transmitter for the 16-bit CPU's UART subsystem. It accepts one byte per request over a start/busy handshake and serializes it on `o_txd` as 8N1 by default: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from an oversampled baud tick produced by the shared baud divider.

## Interface
- `OVERSAMPLE`, default 16: `i_clk_tx` ticks per bit; must be ≥2.
- `STOP_BITS`, default 1: stop bits per frame; legal values are 1 and 2.
- `PARITY_EN`, default 0: when 1, a parity bit is inserted after D7.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN`=0.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `i_clk_tx` in 1: one-`clk`-wide baud tick at OVERSAMPLE× the bit rate.
- `i_tx_start` in 1: transmit request; sampled only while idle.
- `i_tx_data` in 8: byte to send; captured in the accept cycle.
- `o_txd` out 1: serial line, registered, idles high.
- `o_tx_busy` out 1: high from the cycle after accept through the end of the last stop bit.
- `TxDone` out 1: one-`clk` pulse marking frame completion.

## Operation
- **States:** IDLE, START, D0..D7, PARITY, STOP1, STOP2. PARITY is skipped when `PARITY_EN`=0. STOP2 is skipped when `STOP_BITS`=1.
- **Line level per state:**
  - IDLE, STOP1, STOP2: `o_txd` = 1.
  - START: `o_txd` = 0.
  - Dn: `o_txd` = shift-register bit n.
  - PARITY: `o_txd` = XOR(data) ^ `PARITY_ODD`.
- **Accept:** in IDLE with `i_tx_start`=1, capture `i_tx_data` into the shift register, clear the tick counter, and go to START. Any `i_clk_tx` in the accept cycle is not counted.
- **Tick counter:** width is clog2(OVERSAMPLE). It increments on each `i_clk_tx`. On the tick where count == OVERSAMPLE-1, it wraps to 0 and the FSM advances to the next state. Every bit therefore spans exactly OVERSAMPLE ticks.
- **Frame end:** leaving the last stop state returns the FSM to IDLE. In that same transition, `TxDone` is set to 1 for one `clk`.
- **Requests while busy:** `i_tx_start` is ignored outside IDLE and is not queued. Changes on `i_tx_data` after accept have no effect.
- **Back-to-back frames:** a request in the first IDLE cycle, which is the cycle `TxDone` is high, is accepted. This allows frames with no idle gap beyond one `clk`.
- **Ticks in IDLE:** `i_clk_tx` pulses while idle are ignored and the counter holds 0.
- **Reset (including mid-frame):** next `clk` gives `o_txd`=1, `o_tx_busy`=0, `TxDone`=0, FSM=IDLE, counter=0, shift register=0. No `TxDone` is emitted for an aborted frame.

## Timing
- **Reset values:** `o_txd`=1, `o_tx_busy`=0, `TxDone`=0.
- **Accept to line:** with accept in cycle N, `o_txd` falls and `o_tx_busy` rises in cycle N+1.
- **Bit boundaries:** `o_txd` changes in the cycle after the wrapping tick, because the output is registered.
- **Frame length:** (10 + `PARITY_EN` + `STOP_BITS` − 1) × OVERSAMPLE ticks, measured from the first counted tick to `TxDone`. The start bit additionally includes the clk cycles between accept and the first tick.
- **Frame completion:** `TxDone` and the falling edge of `o_tx_busy` occur in the same cycle.
- **Throughput:** one frame in flight; no buffering.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding constants (IDLE, START, D0..D7, PARITY, STOP1, STOP2) as 4-bit localparams;
  - `UART_OVERSAMPLE`=16 default;
  - frame-length helper constant.
- The receiver reuses the package's common state names.
- No sub-module is needed. The tick counter, FSM and shift register stay in `uart_tx`, which is roughly 150 lines.

## Test plan
- **Single frame 0x55, defaults, tick every 4 clk:**
  - `o_txd` = 0,1,0,1,0,1,0,1,0,1 (start through stop), each bit 16 ticks = 64 clk;
  - `TxDone` after 160 ticks;
  - `o_tx_busy` high throughout.
- **Even parity, `PARITY_EN`=1, `PARITY_ODD`=0, byte 0xA5:** parity bit = 0, frame = 11 bits. Rerun with `PARITY_ODD`=1: parity bit = 1.
- **`STOP_BITS`=2, byte 0x00:** line low for 9 bits (start plus data), then high for 32 ticks before `TxDone`.
- **Request handling:**
  - `i_tx_start` pulsed again mid-frame with 0xFF: ignored, frame carries the original byte.
  - Start asserted in the `TxDone` cycle with 0x3C: second frame's start bit follows with a 1-clk gap; two `TxDone` pulses total.
- **Reset mid-frame:** assert `reset`=0 during D3 → next clk `o_txd`=1 and `o_tx_busy`=0; no `TxDone`; a fresh frame 0x81 sends correctly afterwards.
- **Loopback into the existing UART_RX block, sharing `clk` and the 16× tick:** bytes 0x00, 0xFF, 0x5A, 0xC3 are received unchanged, with receiver stop bit = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - 4-bit frame state encodings (IDLE, START, D0..D7, PARITY, STOP1, STOP2)
//     and the enum type built on them
//   - default oversampling ratio and 8N1 frame length
//   - helpers for frame length and parity
package uart_pkg;

    localparam logic [3:0] UART_ST_IDLE   = 4'd0;
    localparam logic [3:0] UART_ST_START  = 4'd1;
    localparam logic [3:0] UART_ST_D0     = 4'd2;
    localparam logic [3:0] UART_ST_D1     = 4'd3;
    localparam logic [3:0] UART_ST_D2     = 4'd4;
    localparam logic [3:0] UART_ST_D3     = 4'd5;
    localparam logic [3:0] UART_ST_D4     = 4'd6;
    localparam logic [3:0] UART_ST_D5     = 4'd7;
    localparam logic [3:0] UART_ST_D6     = 4'd8;
    localparam logic [3:0] UART_ST_D7     = 4'd9;
    localparam logic [3:0] UART_ST_PARITY = 4'd10;
    localparam logic [3:0] UART_ST_STOP1  = 4'd11;
    localparam logic [3:0] UART_ST_STOP2  = 4'd12;

    localparam int UART_OVERSAMPLE = 16;

    // Bits in a default 8N1 frame: start + 8 data + 1 stop.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [3:0] {
        ST_IDLE   = UART_ST_IDLE,
        ST_START  = UART_ST_START,
        ST_D0     = UART_ST_D0,
        ST_D1     = UART_ST_D1,
        ST_D2     = UART_ST_D2,
        ST_D3     = UART_ST_D3,
        ST_D4     = UART_ST_D4,
        ST_D5     = UART_ST_D5,
        ST_D6     = UART_ST_D6,
        ST_D7     = UART_ST_D7,
        ST_PARITY = UART_ST_PARITY,
        ST_STOP1  = UART_ST_STOP1,
        ST_STOP2  = UART_ST_STOP2
    } uart_state_e;

    // Bits per frame for a given parity/stop configuration.
    function automatic int uart_frame_bits(input int parity_en, input int stop_bits);
        return UART_FRAME_BITS + parity_en + stop_bits - 1;
    endfunction

    // Parity bit: even parity over the byte, inverted when odd parity is selected.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter (start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits), timed by an oversampled baud tick.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   i_clk_tx    one-clk baud tick at OVERSAMPLE x bit rate
//   i_tx_start  transmit request, sampled only while idle
//   i_tx_data   byte to send, captured on accept
//   o_txd       registered serial line, idles high
//   o_tx_busy   high from the cycle after accept to the end of the last stop bit
//   TxDone      one-clk pulse at frame completion
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk_tx,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_txd,
    output logic       o_tx_busy,
    output logic       TxDone
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

    uart_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       shreg_r;
    logic             txd_r;
    logic             busy_r;
    logic             done_r;

    uart_state_e      next_state_s;
    logic             next_level_s;

    // State that follows the current one once its bit period has elapsed.
    function automatic uart_state_e next_state(input uart_state_e cur);
        uart_state_e nxt;
        case (cur)
            ST_START:  nxt = ST_D0;
            ST_D0:     nxt = ST_D1;
            ST_D1:     nxt = ST_D2;
            ST_D2:     nxt = ST_D3;
            ST_D3:     nxt = ST_D4;
            ST_D4:     nxt = ST_D5;
            ST_D5:     nxt = ST_D6;
            ST_D6:     nxt = ST_D7;
            ST_D7:     nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP1;
            ST_PARITY: nxt = ST_STOP1;
            ST_STOP1:  nxt = (STOP_BITS == 2) ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Line level driven while in a given state.
    function automatic logic line_level(input uart_state_e st, input logic [7:0] data);
        logic lvl;
        case (st)
            ST_START:  lvl = 1'b0;
            ST_D0:     lvl = data[0];
            ST_D1:     lvl = data[1];
            ST_D2:     lvl = data[2];
            ST_D3:     lvl = data[3];
            ST_D4:     lvl = data[4];
            ST_D5:     lvl = data[5];
            ST_D6:     lvl = data[6];
            ST_D7:     lvl = data[7];
            ST_PARITY: lvl = uart_parity(data, (PARITY_ODD != 0));
            default:   lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    // Successor state and its line level, applied when the bit's last tick arrives.
    always_comb begin
        next_state_s = next_state(state_r);
        next_level_s = line_level(next_state_s, shreg_r);
    end

    // Frame FSM, tick counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            shreg_r <= 8'h00;
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                // Ticks are ignored in idle, including one in the accept cycle.
                cnt_r <= {CNT_W{1'b0}};
                if (i_tx_start) begin
                    shreg_r <= i_tx_data;
                    state_r <= ST_START;
                    txd_r   <= 1'b0;
                    busy_r  <= 1'b1;
                end else begin
                    txd_r  <= 1'b1;
                    busy_r <= 1'b0;
                end
            end else if (i_clk_tx) begin
                if (cnt_r == CNT_MAX) begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= next_state_s;
                    txd_r   <= next_level_s;
                    if (next_state_s == ST_IDLE) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign o_txd     = txd_r;
    assign o_tx_busy = busy_r;
    assign TxDone    = done_r;

endmodule
